// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one shared SIZE-bit adder, round-robin arbitration
// among NREQ requesters. The sum goes into a single-entry result register
// with a valid/ready handshake toward the consumer.
module adder_share_arbiter #(
    parameter int SIZE = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_a,
    input  logic [NREQ*SIZE-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [SIZE-1:0]      rsp_data,
    output logic                 rsp_carry,
    output logic [IDW-1:0]       rsp_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] ptr_nxt;
    logic           found;
    logic           stage_free;
    logic           fire;
    logic [SIZE-1:0] a_w;
    logic [SIZE-1:0] b_w;
    logic [SIZE:0]   sum;

    // The result register can take a new sum if it is empty or being drained now
    assign stage_free = !rsp_valid || rsp_ready;

    // Round-robin search: first valid requester at or after ptr, wrapping
    always_comb begin
        int           idx_i;
        logic [IDW-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx_i = 0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_i = int'(ptr) + k;
            if (idx_i >= NREQ) begin
                idx_i = idx_i - NREQ;
            end
            idx = idx_i[IDW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant is held off during reset and while the result is back-pressured
    always_comb begin
        req_ready = '0;
        if (rst_n && found && stage_free) begin
            req_ready[win] = 1'b1;
        end
    end

    assign fire = |req_ready;

    // Operand mux into the shared adder; carry comes from the extra top bit
    always_comb begin
        a_w = req_a[int'(win)*SIZE +: SIZE];
        b_w = req_b[int'(win)*SIZE +: SIZE];
        sum = {1'b0, a_w} + {1'b0, b_w};
    end

    // Pointer moves to the requester just after the winner
    always_comb begin
        if (win == IDW'(NREQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = win + 1'b1;
        end
    end

    // Result register and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sum[SIZE-1:0];
            rsp_carry <= sum[SIZE];
            rsp_id    <= win;
            ptr       <= ptr_nxt;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the arbiter kept in the bench.
module tb_adder_share_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic         rsp_carry;
    logic [1:0]   rsp_id;

    logic [1:0]   v8;
    logic [15:0]  a8;
    logic [15:0]  b8;
    logic [1:0]   rr8;
    logic         rv8;
    logic         rdy8;
    logic [7:0]   rd8;
    logic         rc8;
    logic         rid8;

    int checks = 0;
    int errors = 0;

    // requester side state
    bit        pend[4];
    bit [31:0] opa[4];
    bit [31:0] opb[4];
    bit        rdy;

    // reference model state
    int        m_ptr;
    bit        m_valid;
    bit [31:0] m_data;
    bit        m_carry;
    int        m_id;

    adder_share_arbiter #(.SIZE(32), .NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_id(rsp_id)
    );

    adder_share_arbiter #(.SIZE(8), .NREQ(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v8), .req_a(a8), .req_b(b8), .req_ready(rr8),
        .rsp_valid(rv8), .rsp_ready(rdy8),
        .rsp_data(rd8), .rsp_carry(rc8), .rsp_id(rid8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*32 +: 32]  = opa[i];
            req_b[i*32 +: 32]  = opb[i];
        end
        rsp_ready = rdy;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_data  = '0;
        m_carry = 0;
        m_id    = 0;
    endtask

    task automatic set_all(input bit [31:0] b);
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1;
            opa[i]  = i;
            opb[i]  = b;
        end
    endtask

    // One clock: starts and ends just after a falling edge.
    task automatic cycle();
        int        w;
        bit        free;
        bit [3:0]  exp_rr;
        bit [32:0] s;
        apply();
        #1;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && pend[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        free   = !m_valid || rdy;
        exp_rr = (w >= 0 && free) ? 4'(1 << w) : 4'b0000;
        chk("req_ready", req_ready, exp_rr);
        if (exp_rr != 0) begin
            s       = 33'(opa[w]) + 33'(opb[w]);
            m_data  = s[31:0];
            m_carry = s[32];
            m_id    = w;
            m_valid = 1;
            m_ptr   = (w + 1) % 4;
            pend[w] = 0;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_data",  rsp_data,  m_data);
        chk("rsp_carry", rsp_carry, m_carry);
        chk("rsp_id",    rsp_id,    m_id);
    endtask

    initial begin
        int exp_ids[6];
        exp_ids = '{3, 0, 1, 2, 3, 0};
        rst_n = 1'b0;
        rdy   = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0; opa[i] = '0; opb[i] = '0;
        end
        v8 = '0; a8 = '0; b8 = '0; rdy8 = 1'b0;
        model_reset();
        apply();
        @(negedge clk);
        @(negedge clk);
        // reset values, and no grant while held in reset
        pend[0] = 1;
        rdy     = 1;
        apply();
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data",  rsp_data, 0);
        chk("rst_carry", rsp_carry, 0);
        chk("rst_id",    rsp_id, 0);
        chk("rst_ready", req_ready, 0);
        pend[0] = 0;
        apply();
        @(negedge clk);
        rst_n = 1'b1;

        // 8-bit instance: carry-out and wrap
        v8 = 2'b01; a8 = 16'h00FF; b8 = 16'h0001; rdy8 = 1'b1;
        #1;
        chk("w8_ready", rr8, 2'b01);
        @(posedge clk); @(negedge clk);
        chk("w8_valid", rv8, 1);
        chk("w8_data",  rd8, 8'h00);
        chk("w8_carry", rc8, 1);
        a8 = 16'h007F;
        @(posedge clk); @(negedge clk);
        chk("w8b_data",  rd8, 8'h80);
        chk("w8b_carry", rc8, 0);
        v8 = 2'b00;

        // single requester 2
        pend[2] = 1; opa[2] = 32'h0000_0100; opb[2] = 32'h0000_0004; rdy = 1;
        cycle();
        chk("t1_data", rsp_data, 32'h0000_0104);
        chk("t1_id",   rsp_id, 2);

        // all valid continuously: rotation starts at 3 since ptr moved there
        for (int n = 0; n < 6; n++) begin
            set_all(32'h10);
            cycle();
            chk("rot_id",   rsp_id, exp_ids[n]);
            chk("rot_data", rsp_data, 32'h10 + exp_ids[n]);
            chk("rot_valid", rsp_valid, 1);
        end

        // backpressure with requesters 1 and 3 pending
        for (int i = 0; i < 4; i++) pend[i] = 0;
        pend[1] = 1; opa[1] = $urandom; opb[1] = $urandom;
        pend[3] = 1; opa[3] = $urandom; opb[3] = $urandom;
        rdy = 0;
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("bp_id", rsp_id, 0);
        end
        rdy = 1;
        cycle();
        chk("bp_rel_id",    rsp_id, 1);
        chk("bp_rel_valid", rsp_valid, 1);

        // reset between clock edges with a result held and ptr=2
        rdy = 0;
        apply();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", rsp_valid, 0);
        chk("mrst_data",  rsp_data, 0);
        chk("mrst_id",    rsp_id, 0);
        chk("mrst_ready", req_ready, 0);
        model_reset();
        set_all(32'h10);
        @(negedge clk);
        rst_n = 1'b1;
        rdy   = 1;
        cycle();
        chk("mrst_first_id", rsp_id, 0);

        // drain, then a one-cycle gap with no requests
        for (int n = 0; n < 3; n++) cycle();
        cycle();
        chk("gap_valid", rsp_valid, 0);
        set_all(32'h20);
        cycle();
        chk("gap_after_id", rsp_id, 0);
        chk("gap_after_valid", rsp_valid, 1);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1;
                    opa[i]  = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
                    opb[i]  = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
                end
            end
            rdy = ($urandom % 4) != 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one SIZE-bit adder among NREQ requesters, e.g. PC+4, branch-target and load/store address generation in multi-cycle or extended datapath variants.
- Round-robin arbitration selects one requester per cycle and drives its operands into the shared adder.
- The sum is captured in a single-entry output register with a valid/ready response interface.
- Throughput is one addition per cycle when the consumer does not stall.

Parameters:
- SIZE, 32, operand and result width in bits (≥1).
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of rsp_id. Derived; must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  bit i: requester i has an operand pair pending.
- req_a  input  NREQ*SIZE  operand A; requester i occupies bits [i*SIZE +: SIZE].
- req_b  input  NREQ*SIZE  operand B, same packing as req_a.
- req_ready  output  NREQ  bit i: requester i is granted and accepted this cycle. One-hot or zero.
- rsp_valid  output  1  result register holds an unconsumed result.
- rsp_ready  input  1  consumer accepts the result this cycle.
- rsp_data  output  SIZE  sum, modulo 2^SIZE.
- rsp_carry  output  1  carry-out (bit SIZE of the full sum).
- rsp_id  output  IDW  index of the requester that produced rsp_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, priority pointer ptr=0.
  - req_ready forced to all-zero while rst_n is low.
- stage_free = !rsp_valid || rsp_ready.
- Arbitration is combinational:
  - The winner w is the first i with req_valid[i]=1, searching ptr, ptr+1, … NREQ-1, 0, … ptr-1.
  - req_ready[w] = stage_free. All other req_ready bits are 0.
  - If no req_valid bit is set, req_ready = 0.
- Fire: req_valid[w] && req_ready[w] at a rising edge.
- On fire:
  - {rsp_carry, rsp_data} <= zero-extended a_w + zero-extended b_w, computed as a (SIZE+1)-bit sum.
  - rsp_id <= w, rsp_valid <= 1, ptr <= (w+1) mod NREQ.
- No fire:
  - ptr holds.
  - If rsp_valid && rsp_ready, then rsp_valid <= 0. rsp_data, rsp_carry and rsp_id hold their last values.
- Latency: result visible the cycle after fire. Sustained rate is one result per cycle while rsp_ready=1.
- Simultaneous response consume and new fire in the same cycle: the new result overwrites the register and rsp_valid stays 1, with no bubble.
- Backpressure: while rsp_valid=1 and rsp_ready=0:
  - req_ready = 0 for all requesters.
  - The register and ptr are held stable.
- Requester rule: once req_valid[i] is asserted, it and its operands stay stable until the cycle req_ready[i]=1. The arbiter does not re-sample dropped requests, and a withdrawn request is simply not granted.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…. Each requester is granted at least once every NREQ fires.
- Overflow: the sum wraps modulo 2^SIZE and rsp_carry reports bit SIZE. No saturation and no signed interpretation.
- Reset mid-operation: any held or pending result is discarded (rsp_valid=0) and ptr returns to 0. After rst_n deasserts, the first fire occurs no earlier than the first rising edge with rst_n high.
- rsp_valid never deasserts without rsp_ready=1, except on reset.

Test Plan:
- SIZE=32: only req_valid[2]=1, a=0x0000_0100, b=0x0000_0004, rsp_ready=1 → req_ready=0100b that cycle; next cycle rsp_valid=1, rsp_data=0x0000_0104, rsp_carry=0, rsp_id=2; ptr becomes 3.
- All four requesters valid continuously with a_i=i, b_i=0x10, rsp_ready=1 → rsp_id sequence 0,1,2,3,0, one result per cycle; rsp_data = 0x10+id.
- SIZE=8: a=0xFF, b=0x01 → rsp_data=0x00, rsp_carry=1. Then a=0x7F, b=0x01 → rsp_data=0x80, rsp_carry=0.
- Backpressure: result held with rsp_ready=0 for 3 cycles while req 1 and req 3 are valid → req_ready=0 and outputs stable throughout; when rsp_ready rises, req 1 fires in that same cycle and rsp_valid stays 1 with the new data.
- Reset mid-operation: rsp_valid=1, ptr=2, then rst_n pulsed low between clock edges → outputs zero immediately and ptr=0; after release with all valid, first grant goes to requester 0.
- Requests with rsp_ready=1 throughout and a 1-cycle gap where no req_valid is set → req_ready=0 and rsp_valid falls for exactly one cycle; ptr unchanged across the gap.
